// File: rtl/axi_mem_tester_if.sv
// rtl/axi_mem_tester_if.sv - AXI4 channel bundle between the memory tester and an xbar slave port
//
// Purpose: groups the AW/W/B/AR/R channels that the tester drives and observes.
// Ports (modport master = tester side, slave = responder side):
//   AW: aw_addr/id/len/size/burst/lock/cache/prot/qos/region/atop/user, aw_valid -> ; <- aw_ready
//   W : w_data/strb/last/user, w_valid ->              ; <- w_ready
//   B : <- b_resp, b_valid                             ; b_ready ->
//   AR: ar_addr/id/len/size/burst/lock/cache/prot/qos/region/user, ar_valid -> ; <- ar_ready
//   R : <- r_data, r_resp, r_last, r_valid             ; r_ready ->
interface axi_mem_tester_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [3:0]              aw_id;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [5:0]              aw_atop;
    logic                    aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [3:0]              ar_id;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic                    ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_mem_tester.sv
// rtl/axi_mem_tester.sv - AXI4 manager that writes an incrementing pattern over a region and reads it back
//
// Purpose: memory / xbar bring-up without a core. Writes num_bursts INCR bursts of
//   seed+global_beat, then reads the same region and counts mismatching beats.
// Optional feature macro: AXI_MEM_TESTER_TIMEOUT_EN (progress watchdog, TIMEOUT_CYCLES).
// Ports:
//   clk_i, arst_ni      clock, asynchronous active-low reset
//   start_i             start pulse, honoured only in IDLE/DONE
//   base_addr_i         region base (burst-size aligned), latched on start
//   num_bursts_i[15:0]  bursts to write then read (0 = empty test), latched on start
//   seed_i              pattern seed, latched on start
//   axi_m               AXI4 manager channels (axi_mem_tester_if.master)
//   busy_o              test running
//   done_o              test finished (level until next accepted start)
//   pass_o              valid with done_o: no errors and no timeout
//   err_count_o[15:0]   saturating error count
//   timeout_o           watchdog fired (0 without the macro)
module axi_mem_tester #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int BURST_LEN      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [15:0]             num_bursts_i,
    input  logic [DATA_WIDTH-1:0]   seed_i,
    axi_mem_tester_if.master        axi_m,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [15:0]             err_count_o,
    output logic                    timeout_o
);
    localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int         BURST_BYTES = BURST_LEN * STRB_WIDTH;
    localparam logic [7:0] LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [2:0] AXI_SIZE    = 3'($clog2(STRB_WIDTH));
    localparam logic [1:0] AXI_INCR    = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [15:0]           nbursts_q, nbursts_d;
    logic [15:0]           burst_q, burst_d;
    logic [7:0]            beat_q, beat_d;
    logic [23:0]           gbeat_q, gbeat_d;   // beat index across the whole pass
    logic [15:0]           err_q, err_d;
    logic                  timeout_q, timeout_d;

    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [15:0]           err_inc;
    logic                  last_beat, last_burst, r_bad, tmo_fire;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign burst_addr = base_q + ADDR_WIDTH'(burst_q) * ADDR_WIDTH'(BURST_BYTES);
    assign exp_data   = seed_q + DATA_WIDTH'(gbeat_q);
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = ((burst_q + 16'd1) == nbursts_q);
    assign err_inc    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

    // Valids and readies decode the registered state only, so they never
    // depend combinationally on the responder's handshake inputs.
    assign axi_m.aw_valid  = (state_q == S_AW);
    assign axi_m.aw_addr   = burst_addr;
    assign axi_m.aw_id     = '0;
    assign axi_m.aw_len    = LAST_BEAT;
    assign axi_m.aw_size   = AXI_SIZE;
    assign axi_m.aw_burst  = AXI_INCR;
    assign axi_m.aw_lock   = 1'b0;
    assign axi_m.aw_cache  = '0;
    assign axi_m.aw_prot   = '0;
    assign axi_m.aw_qos    = '0;
    assign axi_m.aw_region = '0;
    assign axi_m.aw_atop   = '0;
    assign axi_m.aw_user   = 1'b0;

    assign axi_m.w_valid   = (state_q == S_W);
    assign axi_m.w_data    = exp_data;
    assign axi_m.w_strb    = '1;
    assign axi_m.w_last    = (state_q == S_W) && last_beat;
    assign axi_m.w_user    = 1'b0;

    assign axi_m.b_ready   = (state_q == S_B);

    assign axi_m.ar_valid  = (state_q == S_AR);
    assign axi_m.ar_addr   = burst_addr;
    assign axi_m.ar_id     = '0;
    assign axi_m.ar_len    = LAST_BEAT;
    assign axi_m.ar_size   = AXI_SIZE;
    assign axi_m.ar_burst  = AXI_INCR;
    assign axi_m.ar_lock   = 1'b0;
    assign axi_m.ar_cache  = '0;
    assign axi_m.ar_prot   = '0;
    assign axi_m.ar_qos    = '0;
    assign axi_m.ar_region = '0;
    assign axi_m.ar_user   = 1'b0;

    assign axi_m.r_ready   = (state_q == S_R);

    assign aw_hs = axi_m.aw_valid && axi_m.aw_ready;
    assign w_hs  = axi_m.w_valid  && axi_m.w_ready;
    assign b_hs  = axi_m.b_valid  && axi_m.b_ready;
    assign ar_hs = axi_m.ar_valid && axi_m.ar_ready;
    assign r_hs  = axi_m.r_valid  && axi_m.r_ready;

    // A read beat counts as at most one error however many fields are wrong.
    assign r_bad = (axi_m.r_resp != 2'b00) || (axi_m.r_data != exp_data) ||
                   (axi_m.r_last != last_beat);

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = done_o && (err_q == 16'd0) && !timeout_q;
    assign err_count_o = err_q;

`ifdef AXI_MEM_TESTER_TIMEOUT_EN
    // Counts cycles without any handshake; any handshake (hence any state
    // change) restarts it. Fires on the last idle cycle so the FSM spends
    // exactly TIMEOUT_CYCLES cycles stuck before landing in DONE.
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        progress;

    assign progress = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign tmo_fire = busy_o && !progress && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = '0;
        if (busy_o && !progress) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_fire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        seed_d    = seed_q;
        nbursts_d = nbursts_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        gbeat_d   = gbeat_q;
        err_d     = err_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    base_d    = base_addr_i;
                    seed_d    = seed_i;
                    nbursts_d = num_bursts_i;
                    burst_d   = '0;
                    beat_d    = '0;
                    gbeat_d   = '0;
                    err_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = (num_bursts_i == 16'd0) ? S_DONE : S_AW;
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (w_hs) begin
                    beat_d  = beat_q + 8'd1;
                    gbeat_d = gbeat_q + 24'd1;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (b_hs) begin
                    if (axi_m.b_resp != 2'b00) begin
                        err_d = err_inc;
                    end
                    if (last_burst) begin
                        // Write pass complete: rewind to replay the same
                        // addresses and pattern for the read pass.
                        burst_d = '0;
                        beat_d  = '0;
                        gbeat_d = '0;
                        state_d = S_AR;
                    end else begin
                        burst_d = burst_q + 16'd1;
                        state_d = S_AW;
                    end
                end
            end
            S_AR: begin
                if (ar_hs) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (r_hs) begin
                    if (r_bad) begin
                        err_d = err_inc;
                    end
                    beat_d  = beat_q + 8'd1;
                    gbeat_d = gbeat_q + 24'd1;
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = S_DONE;
                        end else begin
                            burst_d = burst_q + 16'd1;
                            state_d = S_AR;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_fire) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            seed_q    <= '0;
            nbursts_q <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            gbeat_q   <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            seed_q    <= seed_d;
            nbursts_q <= nbursts_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            gbeat_q   <= gbeat_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_axi_mem_tester.sv
// tb/tb_axi_mem_tester.sv - self-checking bench for axi_mem_tester with a behavioural AXI RAM
module tb_axi_mem_tester;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int BL  = 8;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] base = '0;
    logic [15:0] nb = '0;
    logic [63:0] seed = '0;
    logic        busy, done, pass, tmo;
    logic [15:0] errc;

    axi_mem_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_mem_tester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .arst_ni(arst_n), .start_i(start), .base_addr_i(base),
        .num_bursts_i(nb), .seed_i(seed), .axi_m(bus), .busy_o(busy), .done_o(done),
        .pass_o(pass), .err_count_o(errc), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder configuration
    logic [63:0] cfg_base, cfg_seed;
    int          cfg_nb, cfg_corrupt, cfg_slverr;
    bit          cfg_drop_rlast, cfg_stall, cfg_hang_aw;

    // Scoreboard / responder state
    logic [63:0] mem [logic [63:0]];
    int          n_aw, n_w, n_b, n_ar, n_r, sb_err, stab_err, aw_vcyc, ar_vcyc;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, r_rem, r_idx;
    bit          b_pend, hs_b, hs_r, aw_pend, w_pend, ar_pend;
    logic [63:0] wr_addr, rd_addr, aw_hold, ar_hold;
    logic [64:0] w_hold;

    function automatic int stall();
        return cfg_stall ? int'($urandom_range(0, 7)) : 0;
    endfunction

    task automatic clear_sb();
        mem.delete();
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        sb_err = 0; stab_err = 0; aw_vcyc = 0; ar_vcyc = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; r_rem = 0; r_idx = 0;
        b_pend = 0; hs_b = 0; hs_r = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
    endtask

    // Monitor: observes pre-edge values at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (arst_n) begin
                if (bus.aw_valid) aw_vcyc++;
                if (bus.ar_valid) ar_vcyc++;
                if (aw_pend && !(bus.aw_valid && bus.aw_addr === aw_hold)) stab_err++;
                if (w_pend && !(bus.w_valid && {bus.w_last, bus.w_data} === w_hold)) stab_err++;
                if (ar_pend && !(bus.ar_valid && bus.ar_addr === ar_hold)) stab_err++;
                aw_pend = bus.aw_valid && !bus.aw_ready; aw_hold = bus.aw_addr;
                w_pend  = bus.w_valid && !bus.w_ready;   w_hold  = {bus.w_last, bus.w_data};
                ar_pend = bus.ar_valid && !bus.ar_ready; ar_hold = bus.ar_addr;

                if (bus.aw_valid && bus.aw_ready) begin
                    if (bus.aw_addr !== cfg_base + 64'(n_aw) * 64'd64 || bus.aw_len !== 8'd7 ||
                        bus.aw_size !== 3'd3 || bus.aw_burst !== 2'd1 ||
                        {bus.aw_id, bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos,
                         bus.aw_region, bus.aw_atop, bus.aw_user} !== '0) sb_err++;
                    wr_addr = bus.aw_addr; n_aw++; aw_cnt = stall();
                end
                if (bus.w_valid && bus.w_ready) begin
                    if (bus.w_data !== cfg_seed + 64'(n_w) || bus.w_strb !== 8'hFF ||
                        bus.w_last !== ((n_w % BL) == BL - 1) || bus.w_user !== 1'b0) sb_err++;
                    mem[wr_addr + 64'((n_w % BL) * 8)] = bus.w_data;
                    if ((n_w % BL) == BL - 1) begin b_pend = 1; b_cnt = stall(); end
                    n_w++; w_cnt = stall();
                end
                if (bus.b_valid && bus.b_ready) begin
                    b_pend = 0; hs_b = 1; n_b++;
                end
                if (bus.ar_valid && bus.ar_ready) begin
                    if (bus.ar_addr !== cfg_base + 64'(n_ar) * 64'd64 || bus.ar_len !== 8'd7 ||
                        bus.ar_size !== 3'd3 || bus.ar_burst !== 2'd1) sb_err++;
                    rd_addr = bus.ar_addr; r_rem = BL; r_idx = 0; n_ar++;
                    ar_cnt = stall(); r_cnt = stall();
                end
                if (bus.r_valid && bus.r_ready) begin
                    r_rem--; r_idx++; n_r++; hs_r = 1; r_cnt = stall();
                end
            end
        end
    end

    // Responder drive: updates on falling edges, well away from the DUT's sampling edge.
    initial begin
        logic [63:0] rd;
        bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
        bus.b_valid = 0; bus.b_resp = 0; bus.r_valid = 0; bus.r_data = 0;
        bus.r_resp = 0; bus.r_last = 0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
                bus.b_valid = 0; bus.r_valid = 0; bus.r_last = 0;
            end else begin
                bus.aw_ready = 0;
                if (bus.aw_valid && !cfg_hang_aw) begin
                    if (aw_cnt == 0) bus.aw_ready = 1; else aw_cnt--;
                end
                bus.w_ready = 0;
                if (bus.w_valid) begin
                    if (w_cnt == 0) bus.w_ready = 1; else w_cnt--;
                end
                bus.ar_ready = 0;
                if (bus.ar_valid) begin
                    if (ar_cnt == 0) bus.ar_ready = 1; else ar_cnt--;
                end
                if (hs_b || !b_pend) bus.b_valid = 0;
                hs_b = 0;
                if (b_pend && !bus.b_valid) begin
                    if (b_cnt == 0) begin
                        bus.b_valid = 1;
                        bus.b_resp  = (n_b == cfg_slverr) ? 2'b10 : 2'b00;
                    end else b_cnt--;
                end
                if (hs_r) bus.r_valid = 0;
                hs_r = 0;
                if (r_rem > 0 && !bus.r_valid) begin
                    if (r_cnt == 0) begin
                        rd = mem[rd_addr + 64'(r_idx * 8)];
                        if (n_r == cfg_corrupt) rd[0] = ~rd[0];
                        bus.r_valid = 1;
                        bus.r_data  = rd;
                        bus.r_resp  = 2'b00;
                        bus.r_last  = (r_idx == BL - 1) && !(cfg_drop_rlast && n_ar == cfg_nb);
                    end else r_cnt--;
                end
            end
        end
    end

    task automatic run_start(input logic [63:0] b, input logic [15:0] n, input logic [63:0] s);
        @(negedge clk);
        base = b; nb = n; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_cfg(input logic [63:0] b, input int n, input logic [63:0] s,
                           input int cor, input int slv, input bit drop, input bit stl);
        cfg_base = b; cfg_nb = n; cfg_seed = s; cfg_corrupt = cor; cfg_slverr = slv;
        cfg_drop_rlast = drop; cfg_stall = stl; cfg_hang_aw = 0;
        clear_sb();
    endtask

    typedef struct {
        logic [63:0] base;
        logic [15:0] nb;
        logic [63:0] seed;
        int          corrupt;
        int          slverr;
        bit          drop_rlast;
        bit          stall;
        logic [15:0] exp_err;
        bit          exp_pass;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{64'h8000_0000, 16'd4, 64'h100, -1, -1, 1'b0, 1'b0, 16'd0, 1'b1};
        vecs[1] = '{64'h1000, 16'd2, 64'hFFFF_FFFF_FFFF_FFFC, -1, -1, 1'b0, 1'b0, 16'd0, 1'b1};
        vecs[2] = '{64'h8000_0000, 16'd4, 64'h100, 5, -1, 1'b0, 1'b0, 16'd1, 1'b0};
        vecs[3] = '{64'h4000, 16'd4, 64'h55, -1, 2, 1'b1, 1'b0, 16'd2, 1'b0};
        vecs[4] = '{64'h2_0000, 16'd16, 64'hABC0, -1, -1, 1'b0, 1'b1, 16'd0, 1'b1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC0, 16'd2, 64'h7, -1, -1, 1'b0, 1'b1, 16'd0, 1'b1};

        set_cfg(0, 0, 0, -1, -1, 0, 0);
        #1;
        check("reset_outputs", {busy, done, pass, tmo, errc}, 0);
        check("reset_valids", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {busy, done, pass}, 0);

        // Empty test: done the cycle after the accepted start, no traffic.
        run_start(64'h9000, 16'd0, 64'h1);
        check("empty_done_next_cycle", {done, pass, busy}, 3'b110);
        repeat (4) @(negedge clk);
        check("empty_no_traffic", {aw_vcyc[15:0], ar_vcyc[15:0]}, 0);
        check("empty_err", errc, 0);

        foreach (vecs[i]) begin
            set_cfg(vecs[i].base, int'(vecs[i].nb), vecs[i].seed, vecs[i].corrupt,
                    vecs[i].slverr, vecs[i].drop_rlast, vecs[i].stall);
            run_start(vecs[i].base, vecs[i].nb, vecs[i].seed);
            check($sformatf("v%0d_busy_after_start", i), {busy, done}, 2'b10);
            // Changed inputs and a start pulse while busy must be ignored.
            base = ~vecs[i].base; nb = 16'd1; seed = 64'h0;
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 0;
            while (!done && cyc < 20000) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("v%0d_done", i), {done, busy}, 2'b10);
            check($sformatf("v%0d_err_count", i), errc, vecs[i].exp_err);
            check($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
            check($sformatf("v%0d_timeout", i), tmo, 0);
            check($sformatf("v%0d_aw_bursts", i), n_aw, vecs[i].nb);
            check($sformatf("v%0d_w_beats", i), n_w, vecs[i].nb * BL);
            check($sformatf("v%0d_r_beats", i), n_r, vecs[i].nb * BL);
            check($sformatf("v%0d_payload_errs", i), sb_err, 0);
            check($sformatf("v%0d_stability_errs", i), stab_err, 0);
        end

        // Hung responder: AW never accepted.
        set_cfg(64'h3000, 4, 64'h10, -1, -1, 0, 0);
        cfg_hang_aw = 1;
        run_start(64'h3000, 16'd4, 64'h10);
`ifdef AXI_MEM_TESTER_TIMEOUT_EN
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_cycles", cyc, TMO);
        check("tmo_flags", {done, busy, tmo, pass}, 4'b1010);
        check("tmo_valids_dropped", {bus.aw_valid, bus.w_valid, bus.ar_valid}, 0);
`else
        repeat (100) @(negedge clk);
        check("hang_still_busy", {busy, done, tmo}, 3'b100);
        check("hang_aw_held", {bus.aw_valid, bus.aw_addr}, {1'b1, 64'h3000});
`endif

        // Asynchronous reset in the middle of the write data phase.
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        set_cfg(64'h5000, 4, 64'h77, -1, -1, 0, 0);
        run_start(64'h5000, 16'd4, 64'h77);
        cyc = 0;
        while (!bus.w_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("midw_reached_w", bus.w_valid, 1);
        #2 arst_n = 1'b0;
        #1;
        check("midw_reset_ctrl", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready,
                                  bus.r_ready, busy, done, pass, tmo}, 0);
        check("midw_reset_payload", {errc, bus.w_data, bus.aw_addr, bus.w_last}, 0);
        @(negedge clk);
        arst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
